// File: rtl/he_latency_match_var.sv
`default_nettype none
// ============================================================================
//  Module   : he_latency_match_var
//  Purpose  : Multi-channel delay line with runtime-programmable latency,
//             stall, reload-with-flush and primed indication.
//             Optional HELM_STATS_EN adds the vcnt output-sample counter.
//  Revision : 1.0  initial release
// ============================================================================
module he_latency_match_var #(
    parameter int W       = 8,
    parameter int NCH     = 1,
    parameter int MAX_LAT = 16,
    parameter int DEF_LAT = 4,
    parameter int LW      = $clog2(MAX_LAT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    input  logic [NCH*W-1:0]  din,
    input  logic [NCH-1:0]    dvld,
    input  logic              lat_ld,
    input  logic [LW-1:0]     lat_in,
    output logic [NCH*W-1:0]  qout,
    output logic [NCH-1:0]    qvld,
    output logic [LW-1:0]     lat_cur,
    output logic              primed,
    output logic              lat_err
`ifdef HELM_STATS_EN
    ,
    output logic [31:0]       vcnt
`endif
);

    localparam logic [LW-1:0] c_one     = LW'(1);
    localparam logic [LW-1:0] c_max_lat = LW'(MAX_LAT);
    localparam logic [LW-1:0] c_def_lat = LW'(DEF_LAT);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic [NCH*W-1:0] r_data [MAX_LAT];
    logic [NCH-1:0]   r_vld  [MAX_LAT];
    logic [LW-1:0]    r_lat_cur;
    logic             r_lat_err;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [LW-1:0]    r_fill_cnt;
    logic [LW-1:0]    w_fill_cnt_nxt;
    logic             w_ld_ok;
    logic             w_accept;

    assign w_ld_ok  = (lat_in >= c_one) && (lat_in <= c_max_lat);
    assign w_accept = lat_ld && w_ld_ok;

    // An accepted load flushes valids only; data is kept so qout may show stale words.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_LAT; i++) begin
                r_data[i] <= '0;
                r_vld[i]  <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < MAX_LAT; i++) begin
                r_vld[i] <= '0;
            end
        end else if (adv) begin
            r_data[0] <= din;
            r_vld[0]  <= dvld;
            for (int i = 1; i < MAX_LAT; i++) begin
                r_data[i] <= r_data[i-1];
                r_vld[i]  <= r_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lat_cur <= c_def_lat;
            r_lat_err <= 1'b0;
        end else begin
            r_lat_err <= lat_ld && !w_ld_ok;
            if (w_accept) begin
                r_lat_cur <= lat_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_FILL;
            r_fill_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fill_cnt <= w_fill_cnt_nxt;
        end
    end

    // Counter parks at zero in RUN so it never exceeds MAX_LAT-1.
    always_comb begin
        w_state_nxt    = r_state;
        w_fill_cnt_nxt = r_fill_cnt;
        if (w_accept) begin
            w_state_nxt    = ST_FILL;
            w_fill_cnt_nxt = '0;
        end else if (adv && (r_state == ST_FILL)) begin
            if (r_fill_cnt == (r_lat_cur - c_one)) begin
                w_state_nxt    = ST_RUN;
                w_fill_cnt_nxt = '0;
            end else begin
                w_fill_cnt_nxt = r_fill_cnt + c_one;
            end
        end
    end

    always_comb begin
        qout = '0;
        qvld = '0;
        for (int i = 0; i < MAX_LAT; i++) begin
            if (r_lat_cur == LW'(i + 1)) begin
                qout = r_data[i];
                qvld = r_vld[i];
            end
        end
    end

    assign lat_cur = r_lat_cur;
    assign primed  = (r_state == ST_RUN);
    assign lat_err = r_lat_err;

`ifdef HELM_STATS_EN
    logic [31:0] r_vcnt;
    logic [31:0] w_pop;
    logic [32:0] w_vcnt_sum;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NCH; i++) begin
            w_pop = w_pop + 32'(qvld[i]);
        end
    end

    assign w_vcnt_sum = {1'b0, r_vcnt} + {1'b0, w_pop};

    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_vcnt <= '0;
        end else if (adv && (qvld != '0)) begin
            r_vcnt <= w_vcnt_sum[32] ? 32'hFFFF_FFFF : w_vcnt_sum[31:0];
        end
    end

    assign vcnt = r_vcnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_he_latency_match_var.sv
`default_nettype none
// ============================================================================
//  Module   : tb_he_latency_match_var
//  Purpose  : Randomized self-checking bench for he_latency_match_var against
//             a history-queue reference model (HELM_STATS_EN aware).
//  Revision : 1.0  initial release
// ============================================================================
module tb_he_latency_match_var;

    localparam int W       = 8;
    localparam int NCH     = 2;
    localparam int MAX_LAT = 16;
    localparam int DEF_LAT = 4;
    localparam int LW      = $clog2(MAX_LAT + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              adv;
    logic [NCH*W-1:0]  din;
    logic [NCH-1:0]    dvld;
    logic              lat_ld;
    logic [LW-1:0]     lat_in;
    logic [NCH*W-1:0]  qout;
    logic [NCH-1:0]    qvld;
    logic [LW-1:0]     lat_cur;
    logic              primed;
    logic              lat_err;
`ifdef HELM_STATS_EN
    logic [31:0]       vcnt;
`endif

    he_latency_match_var #(
        .W(W), .NCH(NCH), .MAX_LAT(MAX_LAT), .DEF_LAT(DEF_LAT), .LW(LW)
    ) u_dut (
        .clk(clk), .rst(rst), .adv(adv), .din(din), .dvld(dvld),
        .lat_ld(lat_ld), .lat_in(lat_in), .qout(qout), .qvld(qvld),
        .lat_cur(lat_cur), .primed(primed), .lat_err(lat_err)
`ifdef HELM_STATS_EN
        , .vcnt(vcnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: every pushed sample is remembered newest-first; the output is the
    // sample pushed L advances ago, valid only once L pushes happened since a flush.
    logic [NCH*W-1:0] m_data[$];
    logic [NCH-1:0]   m_vld[$];
    int               m_since = 0;
    int               m_lat   = DEF_LAT;
    bit               m_err   = 1'b0;
    longint           m_vcnt  = 0;

    function automatic logic [NCH-1:0] exp_qvld();
        return (m_since >= m_lat) ? m_vld[m_lat-1] : '0;
    endfunction

    task automatic model_edge();
        int li;
        li = int'(lat_in);
        if (rst) begin
            m_data.delete();
            m_vld.delete();
            for (int i = 0; i < MAX_LAT; i++) begin
                m_data.push_back('0);
                m_vld.push_back('0);
            end
            m_since = 0;
            m_lat   = DEF_LAT;
            m_err   = 1'b0;
            m_vcnt  = 0;
        end else if (lat_ld && li >= 1 && li <= MAX_LAT) begin
            m_lat   = li;
            m_since = 0;
            m_err   = 1'b0;
            m_vcnt  = 0;
        end else begin
            m_err = lat_ld;
            if (adv) begin
                m_vcnt = m_vcnt + $countones(exp_qvld());
                if (m_vcnt > 64'hFFFF_FFFF) m_vcnt = 64'hFFFF_FFFF;
                m_data.push_front(din);
                m_vld.push_front(dvld);
                void'(m_data.pop_back());
                void'(m_vld.pop_back());
                if (m_since < 1000) m_since++;
            end
        end
    endtask

    task automatic step(input bit a, input bit ld, input int li, input bit r, input logic [NCH-1:0] dv);
        rst    = r;
        adv    = a;
        lat_ld = ld;
        lat_in = LW'(li);
        din    = NCH*W'($urandom);
        dvld   = dv;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("qout",    32'(qout),    32'(m_data[m_lat-1]));
        chk("qvld",    32'(qvld),    32'(exp_qvld()));
        chk("lat_cur", 32'(lat_cur), 32'(m_lat));
        chk("primed",  32'(primed),  32'(m_since >= m_lat));
        chk("lat_err", 32'(lat_err), 32'(m_err));
`ifdef HELM_STATS_EN
        chk("vcnt",    vcnt,         32'(m_vcnt));
`endif
    endtask

    initial begin
        rst = 1'b1; adv = 1'b0; lat_ld = 1'b0; lat_in = '0; din = '0; dvld = '0;
        step(0, 0, 0, 1, 2'b00);
        step(1, 0, 0, 1, 2'b11);
        repeat (20) step(1, 0, 0, 0, 2'b11);
        repeat (3)  step(0, 0, 0, 0, 2'b11);
        repeat (6)  step(1, 0, 0, 0, 2'b11);
        step(1, 1, 1, 0, 2'b11);
        repeat (6)  step(1, 0, 0, 0, 2'b11);
        step(1, 1, 0, 0, 2'b11);
        repeat (3)  step(1, 0, 0, 0, 2'b11);
        step(1, 1, MAX_LAT + 1, 0, 2'b11);
        repeat (3)  step(1, 0, 0, 0, 2'b11);
        step(0, 1, MAX_LAT, 0, 2'b11);
        repeat (8)  step(1, 0, 0, 0, 2'b11);
        repeat (2)  step(0, 0, 0, 0, 2'b11);
        repeat (12) step(1, 0, 0, 0, 2'b11);
        step(1, 1, 7, 0, 2'b01);
        repeat (10) step(1, 0, 0, 0, 2'b10);
        step(1, 0, 0, 1, 2'b11);
        repeat (6)  step(1, 0, 0, 0, 2'b11);
        // Same-value reload still flushes.
        step(1, 1, DEF_LAT, 0, 2'b11);
        repeat (6)  step(1, 0, 0, 0, 2'b11);
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 9) < 8, $urandom_range(0, 29) == 0,
                 int'($urandom_range(0, MAX_LAT + 2)), $urandom_range(0, 199) == 0,
                 NCH'($urandom));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
